// File: rtl/dmx8_pkg.sv
// dmx8_pkg: shared constants and types for the dmx8_frame deserializer.
//   NUM_CH    - channels per frame
//   SEL_W     - width of the channel index
//   ERR_CNT_W - width of the optional error counter
//   state_t   - frame collection state
package dmx8_pkg;

  localparam int unsigned NUM_CH    = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

endpackage

// File: rtl/dmx8_dec.sv
// dmx8_dec: combinational 3-to-8 one-hot write-enable decoder.
// This is the inverse of the 8-to-1 select tree on the serializing side.
// Ports:
//   sel - channel index to enable
//   en  - accept condition; all enables are low when en is low
//   we  - one-hot write enables, we[sel] = en
module dmx8_dec
  import dmx8_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  output logic [NUM_CH-1:0] we
);

  always_comb begin
    we      = '0;
    we[sel] = en;
  end

endmodule

// File: rtl/dmx8_frame.sv
// dmx8_frame: time-multiplexed 1-to-8 demultiplexer / deserializer.
// Collects eight valid beats (first beat flagged by sof_in) into shadow
// registers, then loads y0..y7 atomically on the channel-7 beat.
// Optional macro DMX8_ERR_CNT_EN adds a saturating err_cnt output that
// counts aborts (sof while collecting) and orphan beats (non-sof in IDLE).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   d_in         - serialized channel data (WIDTH bits)
//   valid_in     - d_in carries a beat this cycle
//   sof_in       - beat is channel 0 (start of frame)
//   y0..y7       - registered channel outputs, updated on frame completion
//   frame_valid  - one-cycle pulse when y0..y7 were just loaded
//   sel          - channel index the next non-sof beat will be written to
//   busy         - high while a frame is partially collected
//   err_cnt      - (DMX8_ERR_CNT_EN only) saturating error counter
module dmx8_frame
  import dmx8_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             valid_in,
  input  logic             sof_in,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic             frame_valid,
  output logic [SEL_W-1:0] sel,
  output logic             busy
`ifdef DMX8_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_t           state;
  // Channel 7 is never stored: it goes straight to y7 on completion.
  logic [WIDTH-1:0] shadow [NUM_CH-1];

  logic [SEL_W-1:0]  wr_sel;
  logic              wr_en;
  logic [NUM_CH-1:0] we;
  logic              complete;

  // A sof beat always lands in channel 0; otherwise the tracked sel is used.
  // In COLLECT a non-sof beat enables we[sel]; we[7] is therefore exactly the
  // frame-completion strobe.
  assign wr_sel   = sof_in ? '0 : sel;
  assign wr_en    = valid_in & (sof_in | (state == COLLECT));
  assign complete = we[NUM_CH-1];

  dmx8_dec u_dec (
    .sel (wr_sel),
    .en  (wr_en),
    .we  (we)
  );

  assign busy = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      frame_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH - 1; i++) shadow[i] <= '0;
      y0 <= '0; y1 <= '0; y2 <= '0; y3 <= '0;
      y4 <= '0; y5 <= '0; y6 <= '0; y7 <= '0;
    end else begin
      frame_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
        if (we[i]) shadow[i] <= d_in;
      end
      case (state)
        IDLE: begin
          if (valid_in && sof_in) begin
            sel   <= SEL_W'(1);
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (valid_in) begin
            if (sof_in) begin
              sel <= SEL_W'(1);
            end else if (complete) begin
              y0 <= shadow[0]; y1 <= shadow[1]; y2 <= shadow[2];
              y3 <= shadow[3]; y4 <= shadow[4]; y5 <= shadow[5];
              y6 <= shadow[6]; y7 <= d_in;
              frame_valid <= 1'b1;
              sel         <= '0;
              state       <= IDLE;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

`ifdef DMX8_ERR_CNT_EN
  logic err_evt;
  assign err_evt = valid_in & ((state == IDLE) ? ~sof_in : sof_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_evt && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`else
  // No error counter in this build.
`endif

endmodule

// File: tb/tb_dmx8_frame.sv
module tb_dmx8_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d_in;
  logic       valid_in;
  logic       sof_in;
  logic [3:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic       frame_valid;
  logic [2:0] sel;
  logic       busy;
`ifdef DMX8_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  logic [3:0] ya [8];
  assign ya[0] = y0; assign ya[1] = y1; assign ya[2] = y2; assign ya[3] = y3;
  assign ya[4] = y4; assign ya[5] = y5; assign ya[6] = y6; assign ya[7] = y7;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmx8_frame #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_in        (d_in),
    .valid_in    (valid_in),
    .sof_in      (sof_in),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .y4          (y4),
    .y5          (y5),
    .y6          (y6),
    .y7          (y7),
    .frame_valid (frame_valid),
    .sel         (sel),
    .busy        (busy)
`ifdef DMX8_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  // Present one beat for one clock; returns 1 time unit after the edge.
  task automatic beat(input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    d_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] f [8];
    f = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2};
    // Fill y with a frame, then start another and reset mid-stream.
    for (int i = 0; i < 8; i++) beat(1'b1, i == 0, f[i]);
    beat(1'b1, 1'b1, 4'hC);
    beat(1'b1, 1'b0, 4'hD);
    beat(1'b1, 1'b0, 4'hE);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ya[i] !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_y%0d: got %h expected 0", i, ya[i]);
      end
    end
    vectors++;
    if (sel !== 3'd0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: sel=%0d busy=%b fv=%b expected 0 0 0", sel, busy, frame_valid);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, i == 0, 4'(i + 1));
      if (i < 7) begin
        vectors++;
        if (sel !== 3'(i + 1) || busy !== 1'b1 || frame_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_beat%0d: sel=%0d busy=%b fv=%b expected %0d 1 0",
                   i, sel, busy, frame_valid, i + 1);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ya[i] !== 4'(i + 1)) begin
        miscompares++;
        $display("FAIL basic_y%0d: got %h expected %h", i, ya[i], 4'(i + 1));
      end
    end
    vectors++;
    if (frame_valid !== 1'b1 || sel !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: fv=%b sel=%0d busy=%b expected 1 0 0", frame_valid, sel, busy);
    end
    beat(1'b0, 1'b0, 4'h0);
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_fv_pulse: got %b expected 0", frame_valid);
    end
  endtask

  task automatic test_gapped_frame();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, i == 0, 4'(i + 1));
      if (frame_valid === 1'b1) pulses++;
      if (i < 7) begin
        beat(1'b0, 1'b1, 4'hF);  // sof without valid must be ignored
        if (frame_valid === 1'b1) pulses++;
        vectors++;
        if (busy !== 1'b1 || sel !== 3'(i + 1) || y0 !== 4'h0) begin
          miscompares++;
          $display("FAIL gap_hold%0d: busy=%b sel=%0d y0=%h expected 1 %0d 0",
                   i, busy, sel, y0, i + 1);
        end
      end
    end
    vectors++;
    if (frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_fv: got %b expected 1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ya[i] !== 4'(i + 1)) begin
        miscompares++;
        $display("FAIL gap_y%0d: got %h expected %h", i, ya[i], 4'(i + 1));
      end
    end
    beat(1'b0, 1'b0, 4'h0);
    if (frame_valid === 1'b1) pulses++;
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL gap_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_abort();
    logic [3:0] f1 [8];
    f1 = '{4'hA, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3};
    for (int i = 0; i < 8; i++) beat(1'b1, i == 0, f1[i]);
    beat(1'b1, 1'b1, 4'h1);
    beat(1'b1, 1'b0, 4'h2);
    beat(1'b1, 1'b0, 4'h3);
    beat(1'b1, 1'b1, 4'hF);  // abort and restart
    vectors++;
    if (sel !== 3'd1 || busy !== 1'b1 || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_restart: sel=%0d busy=%b fv=%b expected 1 1 0", sel, busy, frame_valid);
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (ya[i] !== f1[i]) begin
        miscompares++;
        $display("FAIL abort_hold_y%0d: got %h expected %h", i, ya[i], f1[i]);
      end
      beat(1'b1, 1'b0, 4'(14 - i));  // E..8
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ya[i] !== 4'(15 - i)) begin
        miscompares++;
        $display("FAIL abort_y%0d: got %h expected %h", i, ya[i], 4'(15 - i));
      end
    end
    vectors++;
    if (frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_fv: got %b expected 1", frame_valid);
    end
`ifdef DMX8_ERR_CNT_EN
    vectors++;
    if (err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL abort_err_cnt: got %0d expected 1", err_cnt);
    end
`endif
  endtask

  // sof while sel==7 is an abort, not a completion.
  task automatic test_abort_at_7();
    for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 4'h5);
    vectors++;
    if (sel !== 3'd7) begin
      miscompares++;
      $display("FAIL abort7_sel: got %0d expected 7", sel);
    end
    beat(1'b1, 1'b1, 4'h2);
    vectors++;
    if (frame_valid !== 1'b0 || sel !== 3'd1 || y0 !== 4'hF || y7 !== 4'h8) begin
      miscompares++;
      $display("FAIL abort7: fv=%b sel=%0d y0=%h y7=%h expected 0 1 f 8", frame_valid, sel, y0, y7);
    end
    for (int i = 1; i < 8; i++) beat(1'b1, 1'b0, 4'(i + 2));
    vectors++;
    if (frame_valid !== 1'b1 || y0 !== 4'h2 || y1 !== 4'h3 || y7 !== 4'h9) begin
      miscompares++;
      $display("FAIL abort7_done: fv=%b y0=%h y1=%h y7=%h expected 1 2 3 9", frame_valid, y0, y1, y7);
    end
  endtask

  task automatic test_orphan_back_to_back();
    logic [3:0] f [16];
    f = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6,
          4'h5, 4'h3, 4'h5, 4'h8, 4'h9, 4'h7, 4'h9, 4'hE};
    apply_reset();
    beat(1'b1, 1'b0, 4'h7);
    beat(1'b1, 1'b0, 4'h6);
    vectors++;
    if (sel !== 3'd0 || busy !== 1'b0 || frame_valid !== 1'b0 || y0 !== 4'h0) begin
      miscompares++;
      $display("FAIL orphan: sel=%0d busy=%b fv=%b y0=%h expected 0 0 0 0", sel, busy, frame_valid, y0);
    end
    for (int k = 0; k < 16; k++) begin
      beat(1'b1, (k % 8) == 0, f[k]);
      vectors++;
      if (frame_valid !== ((k == 7) || (k == 15))) begin
        miscompares++;
        $display("FAIL b2b_fv%0d: got %b expected %b", k, frame_valid, (k == 7) || (k == 15));
      end
      if (k == 7) begin
        for (int i = 0; i < 8; i++) begin
          vectors++;
          if (ya[i] !== f[i]) begin
            miscompares++;
            $display("FAIL b2b_f1_y%0d: got %h expected %h", i, ya[i], f[i]);
          end
        end
      end
      if (k == 8) begin
        vectors++;
        if (sel !== 3'd1 || busy !== 1'b1 || y0 !== f[0]) begin
          miscompares++;
          $display("FAIL b2b_sof: sel=%0d busy=%b y0=%h expected 1 1 %h", sel, busy, y0, f[0]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ya[i] !== f[i + 8]) begin
        miscompares++;
        $display("FAIL b2b_f2_y%0d: got %h expected %h", i, ya[i], f[i + 8]);
      end
    end
`ifdef DMX8_ERR_CNT_EN
    vectors++;
    if (err_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL orphan_err_cnt: got %0d expected 2", err_cnt);
    end
`endif
  endtask

`ifdef DMX8_ERR_CNT_EN
  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 254; i++) beat(1'b1, 1'b0, 4'h1);
    vectors++;
    if (err_cnt !== 8'd254) begin
      miscompares++;
      $display("FAIL sat_254: got %0d expected 254", err_cnt);
    end
    beat(1'b1, 1'b0, 4'h1);
    vectors++;
    if (err_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_255: got %0d expected 255", err_cnt);
    end
    for (int i = 0; i < 45; i++) beat(1'b1, 1'b0, 4'h1);
    vectors++;
    if (err_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_hold: got %0d expected 255", err_cnt);
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    d_in     = 4'h0;
    apply_reset();
    vectors++;
    if (sel !== 3'd0 || busy !== 1'b0 || frame_valid !== 1'b0 || y7 !== 4'h0) begin
      miscompares++;
      $display("FAIL initial_reset: sel=%0d busy=%b fv=%b y7=%h expected 0 0 0 0", sel, busy, frame_valid, y7);
    end
    test_basic_frame();
    test_reset();
    test_gapped_frame();
    test_abort();
    test_abort_at_7();
    test_orphan_back_to_back();
`ifdef DMX8_ERR_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
